// File: rtl/quad_rpm_error.sv
// rtl/quad_rpm_error.sv - quadrature encoder speed measurement and speed error for a PI loop
//
// Counts decoded quadrature steps over a fixed window of clk cycles, converts the
// count to a sign-magnitude fixed-point speed and subtracts it from the setpoint.
//
// Ports:
//   clk          rising-edge clock for every register
//   reset_n      asynchronous active-low reset
//   enable       high = measure; low = window/accumulator held cleared, pipeline aborted
//   enc_a, enc_b raw quadrature channels (asynchronous to clk)
//   setpoint     target speed, sign-magnitude, Q_WIDTH fractional bits, counts/window
//   speed        last measured speed, same format
//   error_k      setpoint - speed, same format, magnitude saturated
//   error_valid  one-cycle pulse when speed/error_k/flags update
//   count_ovf    window count saturated (valid with error_valid)
//   quad_err     illegal quadrature transition seen in the window (valid with error_valid)
module quad_rpm_error #(
    parameter int WINDOW_CYCLES = 4100,
    parameter int N_WIDTH       = 17,
    parameter int Q_WIDTH       = 8,
    parameter int MAX_COUNT     = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic [N_WIDTH-1:0] setpoint,
    output logic [N_WIDTH-1:0] speed,
    output logic [N_WIDTH-1:0] error_k,
    output logic               error_valid,
    output logic               count_ovf,
    output logic               quad_err
);

    localparam int CW = $clog2(MAX_COUNT + 1) + 1;
    localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int MW = N_WIDTH - 1;
    localparam int IW = N_WIDTH - 1 - Q_WIDTH;
    localparam int EW = N_WIDTH + 1;

    localparam logic signed [CW-1:0] CNT_MAX  = CW'(MAX_COUNT);
    localparam logic signed [CW-1:0] CNT_MIN  = -CNT_MAX;
    localparam logic signed [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [WW-1:0]        WIN_LAST = WW'(WINDOW_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronizer and previous-state register
    // ------------------------------------------------------------------
    logic a_s1, a_s2, a_prev;
    logic b_s1, b_s2, b_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_s1   <= 1'b0;
            a_s2   <= 1'b0;
            a_prev <= 1'b0;
            b_s1   <= 1'b0;
            b_s2   <= 1'b0;
            b_prev <= 1'b0;
        end else begin
            a_s1   <= enc_a;
            a_s2   <= a_s1;
            a_prev <= a_s2;
            b_s1   <= enc_b;
            b_s2   <= b_s1;
            b_prev <= b_s2;
        end
    end

    // Map the Gray sequence 00->01->11->10 onto 0..3 so a step is a modulo-4 difference.
    function automatic logic [1:0] phase(input logic [1:0] ba);
        case (ba)
            2'b00:   phase = 2'd0;
            2'b01:   phase = 2'd1;
            2'b11:   phase = 2'd2;
            default: phase = 2'd3;
        endcase
    endfunction

    logic [1:0] delta;
    logic       step_up, step_dn, illegal;

    assign delta   = phase({b_s2, a_s2}) - phase({b_prev, a_prev});
    assign step_up = enable && (delta == 2'd1);
    assign step_dn = enable && (delta == 2'd3);
    assign illegal = enable && (delta == 2'd2);

    // ------------------------------------------------------------------
    // Window counter and saturating accumulator
    // ------------------------------------------------------------------
    logic [WW-1:0]        win_cnt;
    logic signed [CW-1:0] acc, acc_next;
    logic                 ovf_flag, qerr_flag, ovf_step;
    logic                 terminal;

    logic signed [CW-1:0] cap_count;
    logic                 cap_ovf, cap_qerr, cap_valid;

    assign terminal = enable && (win_cnt == WIN_LAST);

    always_comb begin
        acc_next = acc;
        ovf_step = 1'b0;
        if (step_up) begin
            if (acc == CNT_MAX) ovf_step = 1'b1;
            else                acc_next = acc + CNT_ONE;
        end else if (step_dn) begin
            if (acc == CNT_MIN) ovf_step = 1'b1;
            else                acc_next = acc - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt   <= '0;
            acc       <= '0;
            ovf_flag  <= 1'b0;
            qerr_flag <= 1'b0;
            cap_count <= '0;
            cap_ovf   <= 1'b0;
            cap_qerr  <= 1'b0;
            cap_valid <= 1'b0;
        end else if (!enable) begin
            win_cnt   <= '0;
            acc       <= '0;
            ovf_flag  <= 1'b0;
            qerr_flag <= 1'b0;
            cap_valid <= 1'b0;
        end else begin
            cap_valid <= terminal;
            if (terminal) begin
                // The terminal cycle's own step is part of the closing window.
                cap_count <= acc_next;
                cap_ovf   <= ovf_flag | ovf_step;
                cap_qerr  <= qerr_flag | illegal;
                win_cnt   <= '0;
                acc       <= '0;
                ovf_flag  <= 1'b0;
                qerr_flag <= 1'b0;
            end else begin
                win_cnt   <= win_cnt + WW'(1);
                acc       <= acc_next;
                ovf_flag  <= ovf_flag | ovf_step;
                qerr_flag <= qerr_flag | illegal;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: count -> sign-magnitude speed (zero count yields +0)
    // ------------------------------------------------------------------
    logic               cap_neg;
    logic [IW-1:0]      cap_mag;
    logic [N_WIDTH-1:0] s1_word;
    logic [N_WIDTH-1:0] s1_speed;
    logic               s1_ovf, s1_qerr, s1_valid;

    assign cap_neg = cap_count[CW-1];
    assign cap_mag = IW'(cap_neg ? -cap_count : cap_count);
    assign s1_word = {cap_neg, cap_mag, {Q_WIDTH{1'b0}}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_speed <= '0;
            s1_ovf   <= 1'b0;
            s1_qerr  <= 1'b0;
            s1_valid <= 1'b0;
        end else if (!enable) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= cap_valid;
            if (cap_valid) begin
                s1_speed <= s1_word;
                s1_ovf   <= cap_ovf;
                s1_qerr  <= cap_qerr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: error = setpoint - speed, in two's complement one bit wider
    // than the word so the full +/-2*max range is representable.
    // A -0 setpoint negates to 0 and so behaves as +0.
    // ------------------------------------------------------------------
    logic signed [EW-1:0] sp_val, sv_val, diff;
    logic                 d_neg;
    logic [MW:0]          d_abs;
    logic [MW-1:0]        err_mag;
    logic [N_WIDTH-1:0]   err_word;

    assign sp_val   = setpoint[MW] ? -$signed({2'b00, setpoint[MW-1:0]})
                                   :  $signed({2'b00, setpoint[MW-1:0]});
    assign sv_val   = s1_speed[MW] ? -$signed({2'b00, s1_speed[MW-1:0]})
                                   :  $signed({2'b00, s1_speed[MW-1:0]});
    assign diff     = sp_val - sv_val;
    assign d_neg    = diff[EW-1];
    assign d_abs    = N_WIDTH'(d_neg ? -diff : diff);
    assign err_mag  = d_abs[MW] ? '1 : d_abs[MW-1:0];
    assign err_word = {d_neg, err_mag};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            speed       <= '0;
            error_k     <= '0;
            count_ovf   <= 1'b0;
            quad_err    <= 1'b0;
            error_valid <= 1'b0;
        end else begin
            error_valid <= enable && s1_valid;
            if (enable && s1_valid) begin
                speed     <= s1_speed;
                error_k   <= err_word;
                count_ovf <= s1_ovf;
                quad_err  <= s1_qerr;
            end
        end
    end

endmodule
